// File: rtl/pipe_pkg.sv
// Shared types and constants for the elastic pipeline stage register.
// Build option: PIPE_SKID_BUF_EN adds one skid entry at the input and widens
// the occupancy count by one slot.
package pipe_pkg;

    localparam int unsigned PIPE_CTRL_W = 16;
    localparam int unsigned PIPE_DATA_W = 160;

    // A bubble's control field: all zeros means no register/memory write.
    localparam logic [PIPE_CTRL_W-1:0] CTRL_NOP = '0;

`ifdef PIPE_SKID_BUF_EN
    localparam int unsigned PIPE_SKID = 1;
`else
    localparam int unsigned PIPE_SKID = 0;
`endif

    typedef struct packed {
        logic                   valid;
        logic [PIPE_CTRL_W-1:0] ctrl;
        logic [PIPE_DATA_W-1:0] data;
    } pipe_slot_t;

    // Width of the occupancy count for a given depth (skid entry included).
    function automatic int unsigned pipe_cnt_w(input int unsigned depth);
        return $clog2(depth + 1 + PIPE_SKID);
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One slot of the stage register: load a live entry, collapse to a bubble
// (control -> CTRL_NOP, data retained) or hold. Capture edge set by NEG_EDGE.
// Also used as the skid entry when PIPE_SKID_BUF_EN is defined.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int unsigned CTRL_W   = PIPE_CTRL_W,
    parameter int unsigned DATA_W   = PIPE_DATA_W,
    parameter bit          NEG_EDGE = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic              i_bubble,
    input  logic [CTRL_W-1:0] i_ctrl,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [DATA_W-1:0] o_data
);
    localparam logic [CTRL_W-1:0] L_NOP = CTRL_W'(CTRL_NOP);

    logic              r_valid;
    logic [CTRL_W-1:0] r_ctrl;
    logic [DATA_W-1:0] r_data;
    logic              w_valid_nxt;
    logic [CTRL_W-1:0] w_ctrl_nxt;
    logic [DATA_W-1:0] w_data_nxt;

    // Next slot contents: load wins over bubble; otherwise hold.
    always_comb begin
        w_valid_nxt = r_valid;
        w_ctrl_nxt  = r_ctrl;
        w_data_nxt  = r_data;
        if (i_load) begin
            w_valid_nxt = 1'b1;
            w_ctrl_nxt  = i_ctrl;
            w_data_nxt  = i_data;
        end else if (i_bubble) begin
            w_valid_nxt = 1'b0;
            w_ctrl_nxt  = L_NOP;
        end
    end

    if (NEG_EDGE) begin : g_neg
        // Slot register captured on the falling edge.
        always_ff @(negedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_valid <= 1'b0;
                r_ctrl  <= L_NOP;
                r_data  <= '0;
            end else begin
                r_valid <= w_valid_nxt;
                r_ctrl  <= w_ctrl_nxt;
                r_data  <= w_data_nxt;
            end
        end
    end else begin : g_pos
        // Slot register captured on the rising edge.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_valid <= 1'b0;
                r_ctrl  <= L_NOP;
                r_data  <= '0;
            end else begin
                r_valid <= w_valid_nxt;
                r_ctrl  <= w_ctrl_nxt;
                r_data  <= w_data_nxt;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_ctrl  = r_ctrl;
    assign o_data  = r_data;

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic inter-stage pipeline register: DEPTH slots with valid/ready
// handshake, bubble collapse, hold, flush and a registered occupancy count.
// Build option: PIPE_SKID_BUF_EN adds a skid entry and registers ready_o.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned CTRL_W   = PIPE_CTRL_W,
    parameter int unsigned DATA_W   = PIPE_DATA_W,
    parameter int unsigned DEPTH    = 1,
    parameter bit          NEG_EDGE = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         valid_i,
    output logic                         ready_o,
    input  logic [CTRL_W-1:0]            ctrl_i,
    input  logic [DATA_W-1:0]            data_i,
    input  logic                         hold_i,
    input  logic                         flush_i,
    output logic                         valid_o,
    input  logic                         ready_i,
    output logic [CTRL_W-1:0]            ctrl_o,
    output logic [DATA_W-1:0]            data_o,
    output logic [pipe_cnt_w(DEPTH)-1:0] count_o
);
    localparam int unsigned       CNT_W = pipe_cnt_w(DEPTH);
    localparam logic [CTRL_W-1:0] L_NOP = CTRL_W'(CTRL_NOP);

    logic [DEPTH-1:0]  w_valid;
    logic [DEPTH-1:0]  w_adv;
    logic [DEPTH-1:0]  w_load;
    logic [DEPTH-1:0]  w_bubble;
    logic [CTRL_W-1:0] w_ctrl     [DEPTH];
    logic [DATA_W-1:0] w_data     [DEPTH];
    logic [CTRL_W-1:0] w_src_ctrl [DEPTH];
    logic [DATA_W-1:0] w_src_data [DEPTH];
    logic              w_flow;
    logic              w_s0_open;
    logic              w_xfer_in;
    logic              w_xfer_out;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  w_count_nxt;

    // Advance chain, resolved from head back to tail so a slot may move into
    // a neighbour that is itself moving on this edge.
    always_comb begin
        w_flow         = !hold_i && !flush_i;
        w_xfer_out     = w_valid[DEPTH-1] && ready_i && !hold_i;
        w_adv          = '0;
        w_adv[DEPTH-1] = w_xfer_out && !flush_i;
        for (int unsigned j = DEPTH - 1; j > 0; j--) begin
            w_adv[j-1] = w_valid[j-1] && w_flow && (!w_valid[j] || w_adv[j]);
        end
        w_s0_open = w_flow && (!w_valid[0] || w_adv[0]);
    end

`ifdef PIPE_SKID_BUF_EN
    logic              w_skid_valid;
    logic [CTRL_W-1:0] w_skid_ctrl;
    logic [DATA_W-1:0] w_skid_data;
    logic              w_skid_load;
    logic              w_skid_bubble;
    logic              w_skid_valid_nxt;
    logic              r_ready;

    // Skid entry: park an accept that slot 0 cannot take; drain it first.
    // r_ready is low whenever the entry is occupied, so it never overflows.
    always_comb begin
        w_xfer_in        = valid_i && r_ready && !flush_i;
        w_skid_load      = w_xfer_in && (w_skid_valid || !w_s0_open);
        w_skid_bubble    = flush_i || (w_skid_valid && w_s0_open && !w_skid_load);
        w_skid_valid_nxt = !flush_i && (w_skid_load || (w_skid_valid && !w_s0_open));
    end

    pipe_slot #(
        .CTRL_W   (CTRL_W),
        .DATA_W   (DATA_W),
        .NEG_EDGE (NEG_EDGE)
    ) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (w_skid_load),
        .i_bubble (w_skid_bubble),
        .i_ctrl   (ctrl_i),
        .i_data   (data_i),
        .o_valid  (w_skid_valid),
        .o_ctrl   (w_skid_ctrl),
        .o_data   (w_skid_data)
    );

    if (NEG_EDGE) begin : g_rdy_neg
        // Registered ready: open only if the skid entry ends this edge empty.
        always_ff @(negedge clk or negedge rst_n) begin
            if (!rst_n) r_ready <= 1'b1;
            else        r_ready <= !w_skid_valid_nxt && w_flow;
        end
    end else begin : g_rdy_pos
        // Registered ready: open only if the skid entry ends this edge empty.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) r_ready <= 1'b1;
            else        r_ready <= !w_skid_valid_nxt && w_flow;
        end
    end

    assign ready_o = r_ready;
`else
    assign ready_o   = w_s0_open;
    assign w_xfer_in = valid_i && w_s0_open;
`endif

    // Slot load/bubble controls and data sources.
    always_comb begin
        w_load     = '0;
        w_bubble   = '0;
        w_src_ctrl = '{default: '0};
        w_src_data = '{default: '0};
`ifdef PIPE_SKID_BUF_EN
        w_load[0]     = w_s0_open && (w_skid_valid || w_xfer_in);
        w_src_ctrl[0] = w_skid_valid ? w_skid_ctrl : ctrl_i;
        w_src_data[0] = w_skid_valid ? w_skid_data : data_i;
`else
        w_load[0]     = w_xfer_in;
        w_src_ctrl[0] = ctrl_i;
        w_src_data[0] = data_i;
`endif
        for (int unsigned k = 1; k < DEPTH; k++) begin
            w_load[k]     = w_adv[k-1];
            w_src_ctrl[k] = w_ctrl[k-1];
            w_src_data[k] = w_data[k-1];
        end
        for (int unsigned k = 0; k < DEPTH; k++) begin
            w_bubble[k] = flush_i || (w_adv[k] && !w_load[k]);
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        pipe_slot #(
            .CTRL_W   (CTRL_W),
            .DATA_W   (DATA_W),
            .NEG_EDGE (NEG_EDGE)
        ) u_slot (
            .clk      (clk),
            .rst_n    (rst_n),
            .i_load   (w_load[g]),
            .i_bubble (w_bubble[g]),
            .i_ctrl   (w_src_ctrl[g]),
            .i_data   (w_src_data[g]),
            .o_valid  (w_valid[g]),
            .o_ctrl   (w_ctrl[g]),
            .o_data   (w_data[g])
        );
    end

    // Occupancy: +1 in, -1 out, cleared by flush.
    always_comb begin
        w_count_nxt = r_count;
        if (flush_i)                      w_count_nxt = '0;
        else if (w_xfer_in && !w_xfer_out) w_count_nxt = r_count + CNT_W'(1);
        else if (!w_xfer_in && w_xfer_out) w_count_nxt = r_count - CNT_W'(1);
    end

    if (NEG_EDGE) begin : g_cnt_neg
        // Occupancy register, falling edge.
        always_ff @(negedge clk or negedge rst_n) begin
            if (!rst_n) r_count <= '0;
            else        r_count <= w_count_nxt;
        end
    end else begin : g_cnt_pos
        // Occupancy register, rising edge.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) r_count <= '0;
            else        r_count <= w_count_nxt;
        end
    end

    assign valid_o = w_valid[DEPTH-1];
    assign ctrl_o  = w_valid[DEPTH-1] ? w_ctrl[DEPTH-1] : L_NOP;
    assign data_o  = w_data[DEPTH-1];
    assign count_o = r_count;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg (default NEG_EDGE=1: capture on falling
// edge, outputs sampled just after the rising edge). With PIPE_SKID_BUF_EN
// defined, a DEPTH=1 skid instance is exercised instead.
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         valid_i;
    logic         hold_i;
    logic         flush_i;
    logic [15:0]  ctrl_i;
    logic [159:0] data_i;
    int           n_tests = 0;
    int           n_fail  = 0;

    function automatic logic [159:0] mk_data(input logic [15:0] c);
        return {5{16'hDA7A, c}};
    endfunction

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One active (falling) edge, then settle just after the rising edge.
    task automatic step();
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] c);
        valid_i = v;
        ctrl_i  = c;
        data_i  = mk_data(c);
    endtask

`ifndef PIPE_SKID_BUF_EN
    logic         d2_ready_o, d2_valid_o, d2_ready_i;
    logic [15:0]  d2_ctrl_o;
    logic [159:0] d2_data_o;
    logic [pipe_cnt_w(2)-1:0] d2_count_o;
    logic         d3_ready_o, d3_valid_o, d3_ready_i;
    logic [15:0]  d3_ctrl_o;
    logic [159:0] d3_data_o;
    logic [pipe_cnt_w(3)-1:0] d3_count_o;
    logic         e_v;

    pipe_stage_reg #(.DEPTH(2)) u_d2 (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(d2_ready_o),
        .ctrl_i(ctrl_i), .data_i(data_i), .hold_i(hold_i), .flush_i(flush_i),
        .valid_o(d2_valid_o), .ready_i(d2_ready_i), .ctrl_o(d2_ctrl_o),
        .data_o(d2_data_o), .count_o(d2_count_o)
    );

    pipe_stage_reg #(.DEPTH(3)) u_d3 (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(d3_ready_o),
        .ctrl_i(ctrl_i), .data_i(data_i), .hold_i(hold_i), .flush_i(flush_i),
        .valid_o(d3_valid_o), .ready_i(d3_ready_i), .ctrl_o(d3_ctrl_o),
        .data_o(d3_data_o), .count_o(d3_count_o)
    );

    initial begin
        int cnt_tab [8] = '{1, 2, 3, 3, 3, 2, 1, 0};
        rst_n = 1'b0; hold_i = 1'b0; flush_i = 1'b0;
        d2_ready_i = 1'b0; d3_ready_i = 1'b0;
        drive(1'b0, 16'h0);
        step();
        check("rst_valid", d3_valid_o, 0);
        check("rst_ctrl",  d3_ctrl_o, 0);
        check("rst_data",  d3_data_o, 0);
        check("rst_count", d3_count_o, 0);
        check("rst_ready", d3_ready_o, 1);
        rst_n = 1'b1;

        // Streaming through DEPTH=3.
        d3_ready_i = 1'b1;
        for (int s = 1; s <= 8; s++) begin
            if (s <= 5) drive(1'b1, 16'(s));
            else        drive(1'b0, 16'h0);
            #1;
            check("st_ready", d3_ready_o, 1);
            step();
            e_v = (s >= 3 && s <= 7);
            check("st_valid", d3_valid_o, e_v);
            check("st_ctrl",  d3_ctrl_o, e_v ? 160'(s - 2) : 160'(0));
            if (e_v) check("st_data", d3_data_o, mk_data(16'(s - 2)));
            check("st_count", d3_count_o, cnt_tab[s-1]);
        end
        d3_ready_i = 1'b0;

        rst_n = 1'b0; #2; rst_n = 1'b1;

        // Backpressure on DEPTH=2.
        drive(1'b1, 16'h0011); #1;
        check("bp_rdy1", d2_ready_o, 1);
        step();
        check("bp_cnt1", d2_count_o, 1);
        check("bp_val1", d2_valid_o, 0);
        drive(1'b1, 16'h0012); #1;
        check("bp_rdy2", d2_ready_o, 1);
        step();
        check("bp_cnt2", d2_count_o, 2);
        check("bp_ctl2", d2_ctrl_o, 16'h0011);
        drive(1'b1, 16'h0013); #1;
        check("bp_rdy3", d2_ready_o, 0);
        step();
        check("bp_cnt3", d2_count_o, 2);
        check("bp_ctl3", d2_ctrl_o, 16'h0011);
        d2_ready_i = 1'b1; #1;
        check("bp_rdy4", d2_ready_o, 1);
        step();
        check("bp_ctl4", d2_ctrl_o, 16'h0012);
        check("bp_cnt4", d2_count_o, 2);
        drive(1'b0, 16'h0); #1;
        step();
        check("bp_ctl5", d2_ctrl_o, 16'h0013);
        check("bp_dat5", d2_data_o, mk_data(16'h0013));
        check("bp_cnt5", d2_count_o, 1);

        // Hold with a valid head and ready_i=1.
        hold_i = 1'b1;
        drive(1'b1, 16'h001F);
        for (int h = 0; h < 3; h++) begin
            #1;
            check("hd_ready", d2_ready_o, 0);
            step();
            check("hd_valid", d2_valid_o, 1);
            check("hd_ctrl",  d2_ctrl_o, 16'h0013);
            check("hd_count", d2_count_o, 1);
        end
        hold_i = 1'b0; d2_ready_i = 1'b0;
        drive(1'b1, 16'h0014); #1;
        check("fl_pre_rdy", d2_ready_o, 1);
        step();
        check("fl_pre_cnt", d2_count_o, 2);

        // Flush beats hold; concurrent input dropped, data retained.
        flush_i = 1'b1; hold_i = 1'b1;
        drive(1'b1, 16'h0015); #1;
        check("fl_ready", d2_ready_o, 0);
        step();
        check("fl_valid", d2_valid_o, 0);
        check("fl_ctrl",  d2_ctrl_o, 0);
        check("fl_count", d2_count_o, 0);
        check("fl_data",  d2_data_o, mk_data(16'h0013));
        flush_i = 1'b0; hold_i = 1'b0;
        drive(1'b0, 16'h0);
        step();
        check("fl_drop_v", d2_valid_o, 0);
        check("fl_drop_c", d2_count_o, 0);

        // Reset in the middle of a stream.
        drive(1'b1, 16'h0021); step();
        drive(1'b1, 16'h0022); step();
        drive(1'b0, 16'h0);
        check("mr_pre_cnt", d2_count_o, 2);
        rst_n = 1'b0; #1;
        check("mr_valid", d2_valid_o, 0);
        check("mr_ctrl",  d2_ctrl_o, 0);
        check("mr_count", d2_count_o, 0);
        check("mr_data",  d2_data_o, 0);
        check("mr_ready", d2_ready_o, 1);
        rst_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
`else
    logic         ds_ready_o, ds_valid_o, ds_ready_i;
    logic [15:0]  ds_ctrl_o;
    logic [159:0] ds_data_o;
    logic [pipe_cnt_w(1)-1:0] ds_count_o;

    pipe_stage_reg #(.DEPTH(1)) u_ds (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ds_ready_o),
        .ctrl_i(ctrl_i), .data_i(data_i), .hold_i(hold_i), .flush_i(flush_i),
        .valid_o(ds_valid_o), .ready_i(ds_ready_i), .ctrl_o(ds_ctrl_o),
        .data_o(ds_data_o), .count_o(ds_count_o)
    );

    initial begin
        rst_n = 1'b0; hold_i = 1'b0; flush_i = 1'b0; ds_ready_i = 1'b0;
        drive(1'b0, 16'h0);
        step();
        check("rst_valid", ds_valid_o, 0);
        check("rst_ctrl",  ds_ctrl_o, 0);
        check("rst_data",  ds_data_o, 0);
        check("rst_count", ds_count_o, 0);
        check("rst_ready", ds_ready_o, 1);
        rst_n = 1'b1;

        drive(1'b1, 16'h0031);
        step();
        check("sk_cnt1", ds_count_o, 1);
        check("sk_val1", ds_valid_o, 1);
        check("sk_rdy1", ds_ready_o, 1);
        drive(1'b1, 16'h0032);
        step();
        check("sk_cnt2", ds_count_o, 2);
        check("sk_rdy2", ds_ready_o, 0);
        check("sk_ctl2", ds_ctrl_o, 16'h0031);
        drive(1'b0, 16'h0);
        ds_ready_i = 1'b1;
        step();
        check("sk_ctl3", ds_ctrl_o, 16'h0032);
        check("sk_dat3", ds_data_o, mk_data(16'h0032));
        check("sk_cnt3", ds_count_o, 1);
        check("sk_rdy3", ds_ready_o, 1);
        step();
        check("sk_val4", ds_valid_o, 0);
        check("sk_cnt4", ds_count_o, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
`endif

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised, elastic inter-stage pipeline register for the RV32 pipeline.
- Replaces the fixed, enable-only stage registers (decode/execute and others) with a single reusable block.
- Carries a control field that is bubbled to NOP and a data field that is held, through DEPTH slots.
- Adds valid/ready handshake, hold, flush and an occupancy count. Sits between any two pipeline stages.

Parameters:
- CTRL_W, 16, width of control field (regWrite, memWrite, ALUctrl, ...); forced to CTRL_NOP on a bubble.
- DATA_W, 160, width of data field (PC, RD1, RD2, ImmExt, instr, ...); never cleared except by reset.
- DEPTH, 1, number of register slots, 1..4.
- NEG_EDGE, 1, 1 = capture on falling clk edge, 0 = rising edge.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous active-low reset.
- valid_i  in  1  upstream presents an instruction.
- ready_o  out  1  block accepts on this edge.
- ctrl_i  in  CTRL_W  upstream control field.
- data_i  in  DATA_W  upstream data field.
- hold_i  in  1  hazard-unit stall; freezes all slots.
- flush_i  in  1  branch/jump kill; empties all slots.
- valid_o  out  1  head slot holds a live instruction.
- ready_i  in  1  downstream accepts.
- ctrl_o  out  CTRL_W  head-slot control; CTRL_NOP when valid_o=0.
- data_o  out  DATA_W  head-slot data.
- count_o  out  $clog2(DEPTH+1)  number of valid slots.

Behaviour:
- Active edge is negedge clk if NEG_EDGE=1, else posedge. Reset is asynchronous to either edge.
- Reset (rst_n=0): all slot valid=0, ctrl=CTRL_NOP, data=0, count_o=0, valid_o=0. ready_o follows its combinational equation with all slots empty.
- Slots are numbered 0 (tail, input side) to DEPTH-1 (head, output side). valid_o, ctrl_o and data_o are taken directly from the head slot; no combinational input-to-output path.
- ctrl_o is forced to CTRL_NOP whenever valid_o=0.
- Transfer out occurs when valid_o and ready_i and !hold_i. Transfer in occurs when valid_i and ready_o.
- Slot k advances into slot k+1 if slot k+1 is empty or itself advances (bubble collapse). The head slot advances when the transfer out occurs.
- ready_o = !hold_i && !flush_i && (slot 0 empty || slot 0 advances). This is combinational through the slot chain.
- A slot vacated without a new fill becomes a bubble: valid=0, ctrl=CTRL_NOP, data retained.
- Priority, highest first: reset > flush_i > hold_i > normal flow.
  - flush_i: every slot becomes a bubble on the next edge; the concurrent input is dropped (ready_o=0); count goes to 0.
  - hold_i without flush_i: all slots keep value; ready_o=0; no transfer out even if ready_i=1.
- Latency: DEPTH edges from acceptance to valid_o when unobstructed. Throughput: one per edge.
- Full (count=DEPTH) with ready_i=1: simultaneous in and out are allowed, so ready_o=1. With ready_i=0, ready_o=0.
- Empty: valid_o=0; an input arriving at the same time is not passed through.
- count_o is registered: +1 on transfer in, -1 on transfer out, unchanged on both, 0 on flush.

Optional Feature:
- PIPE_SKID_BUF_EN defined:
  - One extra skid entry at the input. ready_o becomes a register, true when the skid entry is empty and !hold_i && !flush_i, as seen at the previous edge.
  - An input accepted while slot 0 cannot advance is parked in the skid entry. Slot 0 refills from the skid entry before taking new input.
  - count_o includes the skid entry (width $clog2(DEPTH+2)). flush_i also clears the skid entry.
- Not defined: no skid entry; ready_o is combinational as above.

Decomposition:
- Package pipe_pkg: CTRL_NOP constant (all zeros), and pipe_slot_t typedef {valid, ctrl, data} parametrised through localparam widths.
- Sub-module pipe_slot: one slot register with load/bubble/hold controls and edge-select generate. It is instantiated DEPTH times, plus once for the skid entry when PIPE_SKID_BUF_EN is defined.

Test Plan:
- Reset mid-stream: DEPTH=2 with 2 valid slots, pulse rst_n=0 between edges -> immediately valid_o=0, ctrl_o=0, count_o=0, data_o=0.
- Streaming: DEPTH=3, ready_i=1, feed ctrl 0x0001..0x0005 on consecutive edges -> valid_o rises 3 edges after the first accept; outputs 0x0001..0x0005 in order, no gaps; count_o settles at 3.
- Backpressure: DEPTH=2, ready_i=0, feed 3 items -> count_o=2, ready_o=0, third item not accepted. Raise ready_i -> same edge ready_o=1 and third item accepted.
- Hold: with count_o=1 and valid_o=1, assert hold_i and ready_i=1 for 3 edges -> outputs unchanged, ready_o=0, count_o=1.
- Flush over hold: count_o=2, assert flush_i, hold_i and valid_i together -> next edge valid_o=0, ctrl_o=CTRL_NOP, count_o=0, input dropped. data_o keeps its prior value.
- Skid (macro defined): DEPTH=1, slot full and ready_i=0, ready_o registered 1 -> one item parked, count_o=2, ready_o=0 on the next edge. Then ready_i=1 -> items delivered in order.
